// File: rtl/regfile_seq.sv
// Multi-cycle sequencer for the 8x16 register file datapath: latches an instruction,
// then steps through read, compute and write-back. Optional trap: REGFILE_SEQ_ILLEGAL_TRAP_EN.
module regfile_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [3:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_COMPUTE,
        S_COMPUTE_S,
        S_WRITE_REG,
        S_WRITE_IMM
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       vsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d, ctrl_rst;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // IR only moves while idle, so fields stay stable for a whole instruction.
    assign ir_d = ((state_q == S_WAIT) && load) ? in : ir_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:      if (s) state_d = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                state_d = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn) state_d = S_GET_B;
                else if (is_alu)               state_d = S_GET_A;
                else
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
                                               state_d = S_HALT;
`else
                                               state_d = S_WAIT;
`endif
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = is_cmp ? S_COMPUTE_S : S_COMPUTE;
            S_COMPUTE:   state_d = S_WRITE_REG;
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_WAIT;
        endcase
    end

    // Outputs are a function of the next state; IR fields are already stable when
    // they matter, since DECODE drives nothing.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_WAIT:      ctrl_d.w = 1'b1;
            S_GET_A: begin
                ctrl_d.readnum = rn;
                ctrl_d.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_d.readnum = rm;
                ctrl_d.loadb   = 1'b1;
                ctrl_d.shift   = sh;
            end
            S_COMPUTE: begin
                ctrl_d.loadc  = 1'b1;
                ctrl_d.shift  = sh;
                ctrl_d.alu_op = is_alu ? op : 2'b00;
                ctrl_d.asel   = is_mov_reg;
            end
            S_COMPUTE_S: begin
                ctrl_d.loadc  = 1'b1;
                ctrl_d.loads  = 1'b1;
                ctrl_d.shift  = sh;
                ctrl_d.alu_op = 2'b01;
            end
            S_WRITE_REG: begin
                ctrl_d.writenum = rd;
                ctrl_d.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                ctrl_d.writenum = rn;
                ctrl_d.write    = 1'b1;
                ctrl_d.vsel     = 1'b1;
            end
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
            S_HALT:      ctrl_d.illegal = 1'b1;
`endif
            default:     ;
        endcase
    end

    always_comb begin
        ctrl_rst   = '0;
        ctrl_rst.w = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            ctrl_q  <= ctrl_rst;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign w        = ctrl_q.w;
    assign readnum  = ctrl_q.readnum;
    assign writenum = ctrl_q.writenum;
    // A reset sampled at the write-back edge must keep the register file from writing.
    assign write    = ctrl_q.write & ~reset;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign asel     = ctrl_q.asel;
    assign bsel     = 1'b0;
    assign vsel     = ctrl_q.vsel;
    assign shift    = ctrl_q.shift;
    assign ALUop    = ctrl_q.alu_op;
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
    assign illegal  = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: per-cycle expected control vectors are queued at each start
// edge by an instruction-level model and popped by a negedge monitor.
module tb_regfile_seq;
    localparam int W = 36;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] instr_in = '0;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, alu_op;
    logic [15:0] sximm8;
    logic        ill_a;

    always #5 clk = ~clk;

    regfile_seq dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(instr_in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(alu_op),
        .sximm8(sximm8)
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
        , .illegal(ill_a)
`endif
    );

`ifndef REGFILE_SEQ_ILLEGAL_TRAP_EN
    assign ill_a = 1'b0;
`endif

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;

    wire [W-1:0] act = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                        asel, bsel, vsel, shift, alu_op, sximm8, ill_a};

    function automatic logic [W-1:0] v(input logic w_e, input logic [2:0] rn_e, input logic [2:0] wn_e,
                                       input logic wr, input logic la, input logic lb, input logic lc,
                                       input logic ls, input logic as_e, input logic vs,
                                       input logic [1:0] sh_e, input logic [1:0] op_e,
                                       input logic [15:0] imm, input logic ill);
        return {w_e, rn_e, wn_e, wr, la, lb, lc, ls, as_e, 1'b0, vs, sh_e, op_e, imm, ill};
    endfunction

    function automatic bit is_legal(input logic [15:0] ins);
        return (ins[15:13] == 3'b101) ||
               (ins[15:13] == 3'b110 && (ins[12:11] == 2'b10 || ins[12:11] == 2'b00));
    endfunction

    // Reference: the cycle-by-cycle control picture of one instruction, from DECODE
    // through the WAIT cycle that follows it.
    task automatic push_model(input logic [15:0] ins);
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, sh;
        logic [15:0] imm;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8]; rd = ins[7:5];
        sh = ins[4:3]; rm = ins[2:0];
        imm = {{8{ins[7]}}, ins[7:0]};
        exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, imm, 0));
        if (!is_legal(ins)) begin
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
            repeat (2) exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, imm, 1));
            return;
`endif
        end else if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(v(0, 0, rn, 1, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, imm, 0));
        end else begin
            if (opc == 3'b101 && op != 2'b11)
                exp_q.push_back(v(0, rn, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, imm, 0));
            exp_q.push_back(v(0, rm, 0, 0, 0, 1, 0, 0, 0, 0, sh, 2'd0, imm, 0));
            if (opc == 3'b101 && op == 2'b01) begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, sh, 2'b01, imm, 0));
            end else begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, opc == 3'b110, 0, sh,
                                  (opc == 3'b101) ? op : 2'b00, imm, 0));
                exp_q.push_back(v(0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, imm, 0));
            end
        end
        exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, imm, 0));
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL step %0d @%0t: got %h expected %h", step_no, $time, act, e);
            end
            step_no++;
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected cycles still pending after 40 cycles", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0000, 0));
        #1 reset = 1'b0;
        drain();
    endtask

    // Returns just after the start edge with the expected sequence queued.
    task automatic issue(input logic [15:0] ins, input bit together);
        @(posedge clk); #1;
        load = 1'b1; instr_in = ins; s = together;
        if (!together) begin
            @(posedge clk); #1;
            load = 1'b0; instr_in = 16'($urandom()); s = 1'b1;
        end
        @(posedge clk);
        push_model(ins);
        #1 s = 1'b0; load = 1'b0;
    endtask

    task automatic run(input logic [15:0] ins, input bit together);
        issue(ins, together);
        drain();
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
        if (!is_legal(ins)) do_reset();
`endif
    endtask

    task automatic rerun(input logic [15:0] ins);
        @(posedge clk); #1 s = 1'b1;
        @(posedge clk);
        push_model(ins);
        #1 s = 1'b0;
        drain();
    endtask

    initial begin
        logic [15:0] ins;
        logic [31:0] r;
        do_reset();
        run(16'hD205, 1'b1);           // MOV R2,#5
        run(16'hD7FF, 1'b0);           // MOV R7,#-1
        run(16'hA16A, 1'b1);           // ADD R3,R1,R2,LSL
        run(16'hA801, 1'b1);           // CMP R0,R1
        run(16'hC07B, 1'b0);           // MOV R3,R3 with shift, asel path
        run(16'hB8E5, 1'b1);           // MVN R7,R5
        run(16'hB454, 1'b1);           // AND R2,R4,R4,LSR

        // load/s toggled mid-ADD are ignored; the same IR then reruns on s alone
        issue(16'hA6A4, 1'b1);
        @(posedge clk); #1 load = 1'b1; s = 1'b1; instr_in = 16'hD2FF;
        @(posedge clk); #1 load = 1'b0; s = 1'b0;
        drain();
        rerun(16'hA6A4);

        // s held high restarts the same instruction
        @(posedge clk); #1 load = 1'b1; instr_in = 16'hD381; s = 1'b1;
        @(posedge clk);
        push_model(16'hD381);
        push_model(16'hD381);
        #1 load = 1'b0;
        repeat (3) @(posedge clk);
        #1 s = 1'b0;
        drain();

        run(16'h0000, 1'b1);           // illegal

        // reset while in GET_B: back to WAIT, no write-back
        issue(16'hA6A4, 1'b1);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0000, 0));
        #1 reset = 1'b0;
        drain();

        for (int i = 0; i < 40; i++) begin
            r = $urandom();
            case ($urandom_range(0, 6))
                0: ins = {5'b11010, r[10:0]};
                1: ins = {5'b11000, r[10:0]};
                2: ins = {5'b10100, r[10:0]};
                3: ins = {5'b10101, r[10:0]};
                4: ins = {5'b10110, r[10:0]};
                5: ins = {5'b10111, r[10:0]};
                default: ins = r[15:0];
            endcase
            run(ins, bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
